pcie_cfg_mgmt_bridge: RTL and testbench

// - Request/response bridge between core logic and the PCIe hard IP cfg_mgmt port.
// - Accepts one config-space read/write at a time on a valid/ready request channel.
// - Drives the hard IP's level-held cfg_mgmt_read/cfg_mgmt_write strobes.
// - Returns read data, or an error on timeout, on a valid/ready response channel.
// - Sits between the core's cfg_mgmt master and the pcie4_uscale_plus cfg_mgmt slave, on the user clock.

---
 rtl/pcie_cfg_mgmt_bridge.sv | 132 +++++++++++++
 tb/tb_pcie_cfg_mgmt_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cfg_mgmt_bridge.sv
// pcie_cfg_mgmt_bridge: one-at-a-time valid/ready bridge from core logic to the PCIe hard IP cfg_mgmt port,
// holding the read/write strobe until done or timeout and returning data/error on a response channel.
module pcie_cfg_mgmt_bridge #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  s_req_addr,
   input  logic [7:0]  s_req_func,
   input  logic        s_req_write,
   input  logic [31:0] s_req_wdata,
   input  logic [3:0]  s_req_be,
   input  logic        s_req_valid,
   output logic        s_req_ready,
   output logic [31:0] m_rsp_rdata,
   output logic        m_rsp_err,
   output logic        m_rsp_valid,
   input  logic        m_rsp_ready,
   output logic [9:0]  cfg_mgmt_addr,
   output logic [7:0]  cfg_mgmt_function_number,
   output logic        cfg_mgmt_write,
   output logic [31:0] cfg_mgmt_write_data,
   output logic [3:0]  cfg_mgmt_byte_enable,
   output logic        cfg_mgmt_read,
   input  logic [31:0] cfg_mgmt_read_data,
   input  logic        cfg_mgmt_read_write_done,
   output logic        busy,
   output logic [7:0]  timeout_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_req_ready;
   logic          r_busy;
   logic          r_rd;
   logic          r_wr;
   logic [9:0]    r_addr;
   logic [7:0]    r_func;
   logic [31:0]   r_wdata;
   logic [3:0]    r_be;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic          r_rsp_valid;
   logic [7:0]    r_tcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_timer     <= '0;
         r_req_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_func      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_tcnt      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_req_ready <= 1'b1;
               if (s_req_valid && r_req_ready) begin
                  r_addr      <= s_req_addr;
                  r_func      <= s_req_func;
                  r_wdata     <= s_req_wdata;
                  r_be        <= s_req_be;
                  r_wr        <= s_req_write;
                  r_rd        <= !s_req_write;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_timer     <= '0;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               // done takes priority over a timeout landing on the same cycle
               if (cfg_mgmt_read_write_done) begin
                  r_rd        <= 1'b0;
                  r_wr        <= 1'b0;
                  r_rdata     <= r_rd ? cfg_mgmt_read_data : 32'h0;
                  r_err       <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else if (r_timer == TLAST) begin
                  r_rd        <= 1'b0;
                  r_wr        <= 1'b0;
                  r_rdata     <= r_rd ? ERR_RDATA : 32'h0;
                  r_err       <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_tcnt      <= (r_tcnt == 8'hFF) ? r_tcnt : r_tcnt + 8'd1;
                  r_state     <= RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            RESP: begin
               if (m_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rdata     <= '0;
                  r_err       <= 1'b0;
                  r_busy      <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s_req_ready              = r_req_ready;
   assign busy                     = r_busy;
   assign cfg_mgmt_read            = r_rd;
   assign cfg_mgmt_write           = r_wr;
   assign cfg_mgmt_addr            = r_addr;
   assign cfg_mgmt_function_number = r_func;
   assign cfg_mgmt_write_data      = r_wdata;
   assign cfg_mgmt_byte_enable     = r_be;
   assign m_rsp_rdata              = r_rdata;
   assign m_rsp_err                = r_err;
   assign m_rsp_valid              = r_rsp_valid;
   assign timeout_count            = r_tcnt;
endmodule

// File: tb/tb_pcie_cfg_mgmt_bridge.sv
// tb_pcie_cfg_mgmt_bridge: directed bench with a hard-IP responder model and a response scoreboard queue.
module tb_pcie_cfg_mgmt_bridge;
   localparam int          TIMEOUT_CYCLES = 64;
   localparam logic [31:0] ERR_RDATA      = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  s_req_addr;
   logic [7:0]  s_req_func;
   logic        s_req_write;
   logic [31:0] s_req_wdata;
   logic [3:0]  s_req_be;
   logic        s_req_valid;
   logic        s_req_ready;
   logic [31:0] m_rsp_rdata;
   logic        m_rsp_err;
   logic        m_rsp_valid;
   logic        m_rsp_ready;
   logic [9:0]  cfg_mgmt_addr;
   logic [7:0]  cfg_mgmt_function_number;
   logic        cfg_mgmt_write;
   logic [31:0] cfg_mgmt_write_data;
   logic [3:0]  cfg_mgmt_byte_enable;
   logic        cfg_mgmt_read;
   logic [31:0] cfg_mgmt_read_data;
   logic        cfg_mgmt_read_write_done;
   logic        busy;
   logic [7:0]  timeout_count;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   pcie_cfg_mgmt_bridge #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_RDATA(ERR_RDATA)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_req_addr(s_req_addr), .s_req_func(s_req_func), .s_req_write(s_req_write),
      .s_req_wdata(s_req_wdata), .s_req_be(s_req_be), .s_req_valid(s_req_valid),
      .s_req_ready(s_req_ready),
      .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err), .m_rsp_valid(m_rsp_valid),
      .m_rsp_ready(m_rsp_ready),
      .cfg_mgmt_addr(cfg_mgmt_addr), .cfg_mgmt_function_number(cfg_mgmt_function_number),
      .cfg_mgmt_write(cfg_mgmt_write), .cfg_mgmt_write_data(cfg_mgmt_write_data),
      .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable), .cfg_mgmt_read(cfg_mgmt_read),
      .cfg_mgmt_read_data(cfg_mgmt_read_data), .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done),
      .busy(busy), .timeout_count(timeout_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the bridge idle; returns at the negedge after acceptance.
   task automatic start_req(input logic wr, input logic [9:0] a, input logic [7:0] f,
                            input logic [31:0] wd, input logic [3:0] be, input int lat, input logic [31:0] rd);
      rsp_t e;
      chk("req_ready_idle", {31'b0, s_req_ready}, 32'd1);
      s_req_valid = 1'b1;
      s_req_write = wr;
      s_req_addr  = a;
      s_req_func  = f;
      s_req_wdata = wd;
      s_req_be    = be;
      e.err   = (lat == 0);
      e.rdata = wr ? 32'h0 : ((lat == 0) ? ERR_RDATA : rd);
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      s_req_valid = 1'b0;
      s_req_addr  = ~a;
      s_req_wdata = ~wd;
      chk("strobe_wr", {31'b0, cfg_mgmt_write}, {31'b0, wr});
      chk("strobe_rd", {31'b0, cfg_mgmt_read}, {31'b0, !wr});
      chk("cfg_addr", {22'b0, cfg_mgmt_addr}, {22'b0, a});
      chk("cfg_func", {24'b0, cfg_mgmt_function_number}, {24'b0, f});
      chk("cfg_wdata", cfg_mgmt_write_data, wd);
      chk("cfg_be", {28'b0, cfg_mgmt_byte_enable}, {28'b0, be});
      chk("req_ready_issue", {31'b0, s_req_ready}, 32'd0);
      chk("busy_issue", {31'b0, busy}, 32'd1);
   endtask

   // Hard-IP model: pulses done in the lat-th strobe cycle (lat=0 never responds).
   task automatic run_ip(input int lat, input logic [31:0] rd, input logic [9:0] a, input logic [31:0] wd);
      int n = 0;
      while ((cfg_mgmt_read || cfg_mgmt_write) && n < 2 * TIMEOUT_CYCLES) begin
         n++;
         if (n == lat) begin
            cfg_mgmt_read_data       = rd;
            cfg_mgmt_read_write_done = 1'b1;
         end
         @(negedge clk);
         cfg_mgmt_read_write_done = 1'b0;
         cfg_mgmt_read_data       = 32'hDEADBEEF;
      end
      chk("strobe_cycles", n, (lat == 0) ? TIMEOUT_CYCLES : lat);
      chk("addr_held", {22'b0, cfg_mgmt_addr}, {22'b0, a});
      chk("wdata_held", cfg_mgmt_write_data, wd);
      chk("rsp_valid_after_done", {31'b0, m_rsp_valid}, 32'd1);
   endtask

   task automatic do_req(input logic wr, input logic [9:0] a, input logic [7:0] f,
                         input logic [31:0] wd, input logic [3:0] be, input int lat, input logic [31:0] rd);
      start_req(wr, a, f, wd, be, lat, rd);
      run_ip(lat, rd, a, wd);
   endtask

   task automatic collect(input int hold);
      rsp_t e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty: got 0 entries want 1");
         return;
      end
      e = q.pop_front();
      chk("rsp_valid", {31'b0, m_rsp_valid}, 32'd1);
      chk("rsp_rdata", m_rsp_rdata, e.rdata);
      chk("rsp_err", {31'b0, m_rsp_err}, {31'b0, e.err});
      chk("req_ready_resp", {31'b0, s_req_ready}, 32'd0);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, m_rsp_valid}, 32'd1);
         chk("hold_rdata", m_rsp_rdata, e.rdata);
         chk("hold_req_ready", {31'b0, s_req_ready}, 32'd0);
         chk("hold_strobes", {30'b0, cfg_mgmt_read, cfg_mgmt_write}, 32'd0);
      end
      m_rsp_ready = 1'b1;
      @(negedge clk);
      m_rsp_ready = 1'b0;
      chk("rsp_valid_dropped", {31'b0, m_rsp_valid}, 32'd0);
      chk("req_ready_back", {31'b0, s_req_ready}, 32'd1);
      chk("busy_idle", {31'b0, busy}, 32'd0);
      chk("strobes_gap", {30'b0, cfg_mgmt_read, cfg_mgmt_write}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      s_req_addr = '0; s_req_func = '0; s_req_write = 1'b0; s_req_wdata = '0; s_req_be = '0;
      s_req_valid = 1'b0; m_rsp_ready = 1'b0;
      cfg_mgmt_read_data = '0; cfg_mgmt_read_write_done = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", {31'b0, s_req_ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_strobes", {30'b0, cfg_mgmt_read, cfg_mgmt_write}, 32'd0);
      chk("rst_rsp", {m_rsp_rdata[31:2], m_rsp_valid, m_rsp_err}, 32'd0);
      chk("rst_tcnt", {24'b0, timeout_count}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'b0, s_req_ready}, 32'd1);

      // 1: read, done in the 3rd strobe cycle
      do_req(1'b0, 10'h004, 8'h00, 32'h0, 4'hF, 3, 32'h00100406);
      collect(0);

      // 2: write, done in the 1st strobe cycle
      do_req(1'b1, 10'h001, 8'h00, 32'h00000406, 4'b0011, 1, 32'h0);
      collect(0);

      // 3: read timeout, then late done pulses in RESP and IDLE
      do_req(1'b0, 10'h010, 8'h02, 32'h0, 4'hF, 0, 32'h0);
      chk("tcnt_one", {24'b0, timeout_count}, 32'd1);
      cfg_mgmt_read_data = 32'h12345678;
      cfg_mgmt_read_write_done = 1'b1;
      @(negedge clk);
      cfg_mgmt_read_write_done = 1'b0;
      collect(0);
      cfg_mgmt_read_write_done = 1'b1;
      @(negedge clk);
      cfg_mgmt_read_write_done = 1'b0;
      @(negedge clk);
      chk("late_done_busy", {31'b0, busy}, 32'd0);
      chk("late_done_strobes", {30'b0, cfg_mgmt_read, cfg_mgmt_write}, 32'd0);
      chk("late_done_valid", {31'b0, m_rsp_valid}, 32'd0);
      chk("late_done_tcnt", {24'b0, timeout_count}, 32'd1);

      // 4: back-to-back, second request waiting while the first response is stalled
      do_req(1'b0, 10'h020, 8'h01, 32'h0, 4'h1, 2, 32'hCAFE0001);
      s_req_valid = 1'b1; s_req_write = 1'b1; s_req_addr = 10'h021; s_req_wdata = 32'hA5A5A5A5;
      collect(5);
      do_req(1'b1, 10'h021, 8'h01, 32'hA5A5A5A5, 4'hC, 1, 32'h0);
      collect(0);

      // 5: reset mid-ISSUE discards the transaction
      start_req(1'b0, 10'h030, 8'h03, 32'h0, 4'hF, 0, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_read", {31'b0, cfg_mgmt_read}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_valid", {31'b0, m_rsp_valid}, 32'd0);
      chk("midrst_tcnt", {24'b0, timeout_count}, 32'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_req(1'b0, 10'h031, 8'h00, 32'h0, 4'hF, 2, 32'h0BADF00D);
      collect(0);

      // 6: timeout counter saturation
      for (int i = 1; i <= 257; i++) begin
         do_req(1'b1, 10'h040, 8'h00, 32'h1, 4'hF, 0, 32'h0);
         collect(0);
         chk("tcnt_sat", {24'b0, timeout_count}, (i > 255) ? 32'd255 : i);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
